// File: rtl/dmem_responder.sv
// dmem_responder: MEM-stage data-memory slave with fixed latency.
// Serves a big-endian, byte-addressed store and returns raw data.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset
//   req_valid  request present
//   req_ready  idle and able to take a request
//   req_addr   byte address
//   req_wr     1=store, 0=load
//   req_size   0=byte, 1=half, 2=reserved, 3=word
//   req_wdata  store data, right-aligned
//   rsp_valid  response present
//   rsp_ready  requester takes the response
//   rsp_rdata  load data, right-aligned, zero above the access
//   rsp_err    request rejected, memory untouched
module dmem_responder #(
  parameter int SIZE    = 16384,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic        req_wr,
  input  logic [1:0]  req_size,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int WORDS = SIZE / 4;
  localparam int IW =
    (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int CW =
    (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] CNT_INIT =
    CW'(LATENCY - 1);
  localparam logic [32:0] MEM_END =
    33'(SIZE);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] wdata;
  } req_t;

  state_t        r_state;
  state_t        w_next;
  req_t          r_req;
  logic [CW-1:0] r_cnt;
  logic [31:0]   r_rdata;
  logic          r_err;
  logic [31:0]   r_mem [WORDS];

  logic          w_accept;
  logic          w_access;
  logic          w_we;
  logic          w_is_b;
  logic          w_is_h;
  logic          w_is_w;
  logic          w_bad;
  logic          w_range;
  logic          w_err;
  logic [2:0]    w_bytes;
  logic [32:0]   w_end;
  logic [IW-1:0] w_widx;
  logic [4:0]    w_bsh;
  logic [4:0]    w_hsh;
  logic [31:0]   w_word;
  logic [31:0]   w_rd;
  logic [31:0]   w_mask;
  logic [31:0]   w_lane;
  logic [31:0]   w_wnew;

  // ---------------- control FSM ----------------

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_access = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (req_valid) begin
          w_accept = 1'b1;
          w_next   = WAIT;
        end
      end
      WAIT: begin
        if (r_cnt == '0) begin
          w_access = 1'b1;
          w_next   = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          w_next = IDLE;
        end
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  assign req_ready = (r_state == IDLE);
  assign rsp_valid = (r_state == RESP);
  assign rsp_rdata = r_rdata;
  assign rsp_err   = r_err;

  // ---------------- access decode ----------------

  assign w_is_b = (r_req.size == 2'd0);
  assign w_is_h = (r_req.size == 2'd1);
  assign w_is_w = (r_req.size == 2'd3);

  assign w_widx = r_req.addr[IW+1:2];
  assign w_word = r_mem[w_widx];

  // Big-endian lanes: byte offset 0 and the
  // half at addr[1]=0 sit in the high bits.
  assign w_bsh = {~r_req.addr[1:0], 3'b000};
  assign w_hsh = {~r_req.addr[1], 4'b0000};

  always_comb begin
    w_bytes = 3'd4;
    w_bad   = 1'b0;
    w_rd    = w_word;
    w_mask  = 32'hFFFF_FFFF;
    w_lane  = r_req.wdata;
    unique case (1'b1)
      w_is_b: begin
        w_bytes = 3'd1;
        w_rd    = {24'd0, 8'(w_word >> w_bsh)};
        w_mask  = 32'h0000_00FF << w_bsh;
        w_lane  = {4{r_req.wdata[7:0]}};
      end
      w_is_h: begin
        w_bytes = 3'd2;
        w_bad   = r_req.addr[0];
        w_rd    = {16'd0, 16'(w_word >> w_hsh)};
        w_mask  = 32'h0000_FFFF << w_hsh;
        w_lane  = {2{r_req.wdata[15:0]}};
      end
      w_is_w: begin
        w_bad = |r_req.addr[1:0];
      end
      default: begin
        w_bad = 1'b1;
      end
    endcase
  end

  // 33-bit sum so addresses near 2^32 cannot wrap
  // back into range.
  assign w_end =
    {1'b0, r_req.addr} + 33'(w_bytes);
  assign w_range = (w_end > MEM_END);
  assign w_err   = w_bad | w_range;

  assign w_wnew =
    (w_word & ~w_mask) | (w_lane & w_mask);
  assign w_we =
    w_access & r_req.wr & ~w_err;

  // ---------------- datapath registers ----------------

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_req   <= '0;
      r_cnt   <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_req.addr  <= req_addr;
        r_req.wr    <= req_wr;
        r_req.size  <= req_size;
        r_req.wdata <= req_wdata;
        r_cnt       <= CNT_INIT;
      end else if (r_state == WAIT &&
                   r_cnt != '0) begin
        r_cnt <= r_cnt - CW'(1);
      end
      if (w_access) begin
        r_err <= w_err;
        if (w_err || r_req.wr) begin
          r_rdata <= '0;
        end else begin
          r_rdata <= w_rd;
        end
      end
    end
  end

  // Backing store is deliberately not reset.
  always_ff @(posedge clk) begin
    if (w_we) begin
      r_mem[w_widx] <= w_wnew;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: randomized scoreboard bench for dmem_responder.
// Byte-array reference model; monitor pops and compares each response.
module tb_dmem_responder;

  localparam int SIZE = 16384;
  localparam int LAT  = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = '0;
  logic        req_wr = 1'b0;
  logic [1:0]  req_size = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  dmem_responder #(
    .SIZE(SIZE),
    .LATENCY(LAT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_addr(req_addr),
    .req_wr(req_wr),
    .req_size(req_size),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] wdata;
    int          acc;
  } txn_t;

  txn_t        q[$];
  bit [7:0]    mem_m [SIZE];
  int          n_vec = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          rdy_mode = 0;
  bit          seen = 1'b0;
  logic [31:0] hold_rd;
  logic        hold_err;
  txn_t        m_t;
  logic [31:0] m_rd;
  logic        m_err;

  always @(posedge clk) cyc <= cyc + 1;

  // rsp_ready: 0=random, 1=held low, 2=held high
  initial forever begin
    @(posedge clk);
    #2;
    case (rdy_mode)
      0: rsp_ready = ($urandom_range(0, 3) != 0);
      1: rsp_ready = 1'b0;
      default: rsp_ready = 1'b1;
    endcase
  end

  task automatic chk(input string name,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h",
               name, got, exp);
    end
  endtask

  // Reference: memory as a flat byte array, big-endian
  // meaning the lowest address is the most significant.
  function automatic void model(input txn_t t,
                                output logic [31:0] rd,
                                output logic err);
    int n;
    longint a;
    n = (t.size == 2'd0) ? 1 :
        (t.size == 2'd1) ? 2 : 4;
    a = longint'(t.addr);
    err = (t.size == 2'd2) ||
          (t.size == 2'd1 && t.addr[0]) ||
          (t.size == 2'd3 && t.addr[1:0] != 2'd0) ||
          (a + n > SIZE);
    rd = '0;
    if (!err) begin
      for (int i = 0; i < n; i++) begin
        if (t.wr)
          mem_m[a + i] = 8'(t.wdata >> (8 * (n - 1 - i)));
        else
          rd = (rd << 8) | {24'd0, mem_m[a + i]};
      end
    end
  endfunction

  always @(negedge clk) begin
    if (reset) begin
      seen = 1'b0;
    end else if (rsp_valid) begin
      if (!seen) begin
        seen = 1'b1;
        hold_rd = rsp_rdata;
        hold_err = rsp_err;
        if (q.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL unexpected_rsp: got rdata %h, expected none",
                   rsp_rdata);
        end else begin
          chk("latency", 32'(cyc - q[0].acc), 32'(LAT));
        end
        chk("rsp_req_ready", {31'd0, req_ready}, 32'd0);
      end else begin
        chk("hold_rdata", rsp_rdata, hold_rd);
        chk("hold_err", {31'd0, rsp_err}, {31'd0, hold_err});
        chk("hold_req_ready", {31'd0, req_ready}, 32'd0);
      end
      if (rsp_ready) begin
        seen = 1'b0;
        if (q.size() != 0) begin
          m_t = q.pop_front();
          model(m_t, m_rd, m_err);
          chk("rdata", rsp_rdata, m_rd);
          chk("err", {31'd0, rsp_err}, {31'd0, m_err});
        end
      end
    end
  end

  task automatic issue(input logic [31:0] a,
                       input logic wr,
                       input logic [1:0] sz,
                       input logic [31:0] wd,
                       input bit wait_rsp);
    int g;
    txn_t t;
    g = 0;
    @(negedge clk);
    while (!req_ready && g < 200) begin
      @(negedge clk);
      g++;
    end
    if (!req_ready) begin
      n_vec++;
      n_bad++;
      $display("FAIL req_ready_timeout: got 0, expected 1");
      return;
    end
    req_valid = 1'b1;
    req_addr  = a;
    req_wr    = wr;
    req_size  = sz;
    req_wdata = wd;
    @(posedge clk);
    #1;
    t.addr  = a;
    t.wr    = wr;
    t.size  = sz;
    t.wdata = wd;
    t.acc   = cyc;
    q.push_back(t);
    if (!wait_rsp) begin
      req_valid = 1'b0;
      return;
    end
    // Junk store kept valid while busy; it must be ignored.
    req_addr  = 32'($urandom_range(0, 15)) << 2;
    req_wr    = 1'b1;
    req_size  = 2'd3;
    req_wdata = $urandom;
    g = 0;
    do begin
      @(negedge clk);
      g++;
    end while (!rsp_valid && g < 50);
    req_valid = 1'b0;
    if (!rsp_valid) begin
      n_vec++;
      n_bad++;
      $display("FAIL rsp_timeout: got rsp_valid 0, expected 1");
    end
  endtask

  task automatic drain();
    int g;
    g = 0;
    @(negedge clk);
    while ((q.size() != 0 || !req_ready) && g < 200) begin
      @(negedge clk);
      g++;
    end
    chk("drain_q", 32'(q.size()), 32'd0);
  endtask

  // Asynchronous reset mid-cycle; outputs clear at once.
  task automatic mid_reset();
    reset = 1'b1;
    q.delete();
    seen = 1'b0;
    #1;
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    logic [31:0] a;
    int r;
    repeat (3) @(negedge clk);
    chk("init_req_ready", {31'd0, req_ready}, 32'd1);
    chk("init_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("init_rsp_rdata", rsp_rdata, 32'd0);
    chk("init_rsp_err", {31'd0, rsp_err}, 32'd0);
    reset = 1'b0;

    issue(32'h100, 1, 2'd3, 32'hDEADBEEF, 1);
    issue(32'h100, 0, 2'd3, 32'h0, 1);
    issue(32'h101, 0, 2'd0, 32'h0, 1);
    issue(32'h102, 0, 2'd1, 32'h0, 1);
    issue(32'h103, 1, 2'd0, 32'hAAAA_AA55, 1);
    issue(32'h100, 0, 2'd3, 32'h0, 1);
    issue(32'h101, 0, 2'd1, 32'h0, 1);
    issue(32'h100, 0, 2'd2, 32'h0, 1);
    issue(32'h3FFC, 1, 2'd3, 32'h0BAD_F00D, 1);
    issue(32'h4000, 1, 2'd3, 32'hCAFEF00D, 1);
    issue(32'h3FFE, 1, 2'd3, 32'h1111_2222, 1);
    issue(32'h3FFF, 1, 2'd1, 32'h3333_4444, 1);
    issue(32'h3FFF, 1, 2'd0, 32'h0000_0077, 1);
    issue(32'h3FFC, 0, 2'd3, 32'h0, 1);
    issue(32'hFFFF_FFFF, 0, 2'd0, 32'h0, 1);

    drain();
    rdy_mode = 1;
    issue(32'h100, 0, 2'd3, 32'h0, 1);
    repeat (5) begin
      @(negedge clk);
      chk("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      chk("bp_req_ready", {31'd0, req_ready}, 32'd0);
    end
    rdy_mode = 2;
    @(posedge clk);
    #3;
    @(posedge clk);
    #1;
    chk("bp_drop_valid", {31'd0, rsp_valid}, 32'd0);
    chk("bp_idle_ready", {31'd0, req_ready}, 32'd1);

    drain();
    rdy_mode = 1;
    issue(32'h100, 0, 2'd3, 32'h0, 1);
    @(posedge clk);
    #3;
    mid_reset();
    rdy_mode = 0;

    drain();
    issue(32'h200, 1, 2'd3, 32'h12345678, 0);
    @(posedge clk);
    #3;
    mid_reset();
    issue(32'h200, 0, 2'd3, 32'h0, 1);
    issue(32'h202, 0, 2'd1, 32'h0, 1);

    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 3);
      if (r < 2)
        a = 32'($urandom_range(0, 127));
      else if (r == 2)
        a = 32'(SIZE - 8 + $urandom_range(0, 11));
      else
        a = $urandom;
      issue(a, 1'($urandom_range(0, 1)),
            2'($urandom_range(0, 3)), $urandom, 1);
    end

    drain();
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
